// File: rtl/servo_sweep_pkg.sv
// servo_sweep_pkg: shared sweep state encoding and default angle/distance widths
package servo_sweep_pkg;
    localparam int DEF_ANGLE_W = 16;
    localparam int DEF_DIST_W  = 8;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, PARK} state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts enabled cycles and flags the last of CYCLES, then wraps to zero
module settle_timer #(
    parameter int CYCLES = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    // terminal count on the last enabled cycle; clear or terminal count restarts from zero
    always_comb begin
        tc    = en && cnt_q == CW'(CYCLES - 1);
        cnt_d = (clr || tc) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    end
    // count register
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/servo_sweep_ctrl.sv
// servo_sweep_ctrl: sweeps the servo, finds the strongest IR return and parks there; SERVO_SWEEP_TIMEOUT_EN bounds the sample wait
module servo_sweep_ctrl
    import servo_sweep_pkg::*;
#(
    parameter int ANGLE_W       = DEF_ANGLE_W,
    parameter int DIST_W        = DEF_DIST_W,
    parameter int ANGLE_MIN     = 0,
    parameter int ANGLE_MAX     = 180,
    parameter int ANGLE_STEP    = 15,
    parameter int SETTLE_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DIST_W-1:0]  ir_dist,
    input  logic               ir_valid,
    output logic [ANGLE_W-1:0] angle,
    output logic               busy,
    output logic               done,
    output logic [ANGLE_W-1:0] best_angle,
    output logic [DIST_W-1:0]  best_dist
`ifdef SERVO_SWEEP_TIMEOUT_EN
    ,
    output logic               sample_timeout
`endif
);
`ifdef SERVO_SWEEP_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    localparam logic [ANGLE_W-1:0] A_MIN   = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W:0]   MAX_EXT = (ANGLE_W + 1)'(ANGLE_MAX);
    state_t             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d, best_angle_q, best_angle_d;
    logic [DIST_W-1:0]  best_dist_q, best_dist_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               tc, t_en, t_clr, go, got, expired, take, better, last;
    logic [ANGLE_W:0]   next_angle;
    settle_timer #(.CYCLES(SETTLE_CYCLES)) u_timer (
        .clk(clk), .reset(reset), .clr(t_clr), .en(t_en), .tc(tc)
    );
    // next-state, angle stepping and best-return tracking; the wide sum keeps the limit compare from wrapping
    always_comb begin
        go           = state_q == IDLE && start;
        got          = state_q == SAMPLE && ir_valid;
        expired      = state_q == SAMPLE && !ir_valid && tc;
        take         = got || expired;
        better       = got && ir_dist > best_dist_q;
        next_angle   = {1'b0, angle_q} + (ANGLE_W + 1)'(ANGLE_STEP);
        last         = next_angle > MAX_EXT;
        best_angle_d = go ? A_MIN : better ? angle_q : best_angle_q;
        best_dist_d  = go ? '0 : better ? ir_dist : best_dist_q;
        done_d       = state_q == PARK && tc && !done_q;
        state_d      = go ? SETTLE
                     : (state_q == SETTLE && tc) ? SAMPLE
                     : take ? (last ? PARK : SETTLE)
                     : (state_q == PARK && done_q) ? IDLE
                     : state_q;
        angle_d      = go ? A_MIN : take ? (last ? best_angle_d : next_angle[ANGLE_W-1:0]) : angle_q;
        busy_d       = state_d != IDLE && !done_d;
        t_en         = state_q == SETTLE || state_q == PARK || (TMO && state_q == SAMPLE);
        t_clr        = state_q == IDLE || take;
    end
    // sweep state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            angle_q      <= A_MIN;
            best_angle_q <= A_MIN;
            best_dist_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            best_angle_q <= best_angle_d;
            best_dist_q  <= best_dist_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end
`ifdef SERVO_SWEEP_TIMEOUT_EN
    logic tmo_q, tmo_d;
    // sticky flag for a sample window that closed without an IR strobe
    always_comb begin
        tmo_d = go ? 1'b0 : expired ? 1'b1 : tmo_q;
    end
    // timeout flag register
    always_ff @(posedge clk) begin
        tmo_q <= reset ? 1'b0 : tmo_d;
    end
    assign sample_timeout = tmo_q;
`endif
    assign angle      = angle_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_angle = best_angle_q;
    assign best_dist  = best_dist_q;
endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// tb_servo_sweep_ctrl: randomized sweeps against a per-period behavioural model, two step sizes in parallel
module tb_servo_sweep_ctrl;
    localparam int AW = 16, DW = 8, MIN = 0, MAX = 180, S1 = 45, S2 = 40, SC = 4;
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, ir_valid = 1'b0;
    logic [DW-1:0] ir_dist = '0;
    logic [AW-1:0] a1, a2, ba1, ba2;
    logic [DW-1:0] bd1, bd2;
    logic b1, b2, d1, d2;
`ifdef SERVO_SWEEP_TIMEOUT_EN
    logic t1, t2;
`endif
    int n_chk = 0, n_fail = 0;
    int e_idx = 0, e_bidx = 0, e_bd = 0;
    bit e_busy = 0, e_done = 0, e_tmo = 0, chk_en = 0;

    always #5 clk = ~clk;

    servo_sweep_ctrl #(.ANGLE_W(AW), .DIST_W(DW), .ANGLE_MIN(MIN), .ANGLE_MAX(MAX),
                       .ANGLE_STEP(S1), .SETTLE_CYCLES(SC)) dut1 (
        .clk(clk), .reset(reset), .start(start), .ir_dist(ir_dist), .ir_valid(ir_valid),
        .angle(a1), .busy(b1), .done(d1), .best_angle(ba1), .best_dist(bd1)
`ifdef SERVO_SWEEP_TIMEOUT_EN
        , .sample_timeout(t1)
`endif
    );
    servo_sweep_ctrl #(.ANGLE_W(AW), .DIST_W(DW), .ANGLE_MIN(MIN), .ANGLE_MAX(MAX),
                       .ANGLE_STEP(S2), .SETTLE_CYCLES(SC)) dut2 (
        .clk(clk), .reset(reset), .start(start), .ir_dist(ir_dist), .ir_valid(ir_valid),
        .angle(a2), .busy(b2), .done(d2), .best_angle(ba2), .best_dist(bd2)
`ifdef SERVO_SWEEP_TIMEOUT_EN
        , .sample_timeout(t2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // compare process: every period, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("angle_s45", a1, MIN + e_idx * S1);
            chk("angle_s40", a2, MIN + e_idx * S2);
            chk("best_angle_s45", ba1, MIN + e_bidx * S1);
            chk("best_angle_s40", ba2, MIN + e_bidx * S2);
            chk("best_dist_s45", bd1, e_bd);
            chk("best_dist_s40", bd2, e_bd);
            chk("busy_s45", b1, e_busy);
            chk("busy_s40", b2, e_busy);
            chk("done_s45", d1, e_done);
            chk("done_s40", d2, e_done);
`ifdef SERVO_SWEEP_TIMEOUT_EN
            chk("timeout_s45", t1, e_tmo);
            chk("timeout_s40", t2, e_tmo);
`endif
        end
    end

    task automatic cyc(input bit s, input bit v, input int d, input bit r);
        start = s; ir_valid = v; ir_dist = DW'(d); reset = r;
        @(posedge clk);
        #1;
    endtask

    // one sweep; ds[k] < 0 withholds the strobe; abort_k >= 0 resets at that sample's settle
    task automatic sweep(input int ds[5], input bit spur, input int restart_k, input int abort_k);
        int n, bd, bi, w;
        n = (MAX - MIN) / S1 + 1;
        bd = 0; bi = 0;
        cyc(1, 0, 0, 0);
        e_busy = 1; e_done = 0; e_idx = 0; e_bidx = 0; e_bd = 0; e_tmo = 0;
        for (int k = 0; k < n; k++) begin
            e_idx = k;
            for (int s = 0; s < SC; s++) begin
                if (k == abort_k && s == 1) begin
                    cyc(0, 0, 0, 1);
                    e_idx = 0; e_bidx = 0; e_bd = 0; e_busy = 0; e_done = 0; e_tmo = 0;
                    return;
                end
                cyc(k == restart_k && s == 1, spur && $urandom_range(0, 1) == 1, $urandom_range(0, 255), 0);
            end
            if (ds[k] < 0) begin
                for (int s = 0; s < SC; s++) cyc(0, 0, 0, 0);
                e_tmo = 1;
            end else begin
                w = $urandom_range(0, 3);
                for (int s = 0; s < w; s++) cyc(0, 0, 0, 0);
                cyc(0, 1, ds[k], 0);
                if (ds[k] > bd) begin bd = ds[k]; bi = k; end
                e_bidx = bi; e_bd = bd;
            end
        end
        e_idx = bi;
        for (int s = 0; s < SC; s++) cyc(0, 0, 0, 0);
        e_busy = 0; e_done = 1;
        cyc(1, 1, 255, 0);
        e_done = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 1, 200, 0);
    endtask

    initial begin
        int rd[5];
        cyc(0, 0, 0, 1);
        chk_en = 1;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("pin_reset_angle", a1, 0);
        chk("pin_reset_best_dist", bd1, 0);
        sweep('{10, 40, 90, 30, 20}, 0, 2, -1);
        chk("pin_sweep_best_angle", ba1, 90);
        chk("pin_sweep_best_dist", bd1, 90);
        chk("pin_sweep_park_s40", a2, 80);
        sweep('{50, 70, 70, 10, 0}, 1, -1, -1);
        chk("pin_tie_best_angle", ba1, 45);
        chk("pin_tie_best_dist", bd1, 70);
        sweep('{5, 6, 7, 8, 9}, 1, -1, 3);
        cyc(0, 0, 0, 0);
        chk("pin_abort_angle", a1, 0);
        chk("pin_abort_busy", b1, 0);
        sweep('{0, 0, 0, 0, 0}, 1, -1, -1);
        chk("pin_zero_best_angle", ba1, 0);
        chk("pin_zero_park_s40", a2, 0);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 5; i++) rd[i] = $urandom_range(0, 255);
            sweep(rd, 1, $urandom_range(0, 4), r == 5 ? 1 : -1);
        end
`ifdef SERVO_SWEEP_TIMEOUT_EN
        sweep('{10, 20, -1, 5, 1}, 0, -1, -1);
        chk("pin_timeout_flag", t1, 1);
        chk("pin_timeout_best", ba1, 45);
        sweep('{1, 2, 3, 4, 5}, 0, -1, -1);
        chk("pin_timeout_cleared", t1, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
